config_memory_db: RTL and testbench
===================================

CONFIG_MEMORY_DB -- requirements
Module: config_memory_db

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 125, number of words, range 2..256.
REQ-003 The block SHALL have parameter ADDR_W, default 7, address width, SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 The block SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port data_in, input, DATA_W, write data.
REQ-007 The block SHALL have port addr, input, ADDR_W, explicit write/read address.
REQ-008 The block SHALL have port write_enable, input, 1, write strobe for staging bank.
REQ-009 The block SHALL have port auto_inc, input, 1, 1 = write uses internal pointer instead of addr.
REQ-010 The block SHALL have port read_enable, input, 1, staging readback strobe.
REQ-011 The block SHALL have port commit, input, 1, copy staging bank to active bank.
REQ-012 The block SHALL have port data_out, output, DATA_W, registered readback data.
REQ-013 The block SHALL have port rd_valid, output, 1, one-cycle pulse qualifying data_out.
REQ-014 The block SHALL have port addr_err, output, 1, one-cycle pulse on out-of-range access.
REQ-015 The block SHALL have port commit_done, output, 1, one-cycle pulse after commit.
REQ-016 The block SHALL have port all_data_out, output, DEPTH*DATA_W, active bank; word i at bits [i*DATA_W +: DATA_W].

Function
REQ-017 The block SHALL hold two banks, staging and active, each DEPTH x DATA_W registers.
REQ-018 Write address SHALL be wr_ptr when auto_inc=1, else addr.
REQ-019 On write_enable with write address < DEPTH, staging[address] SHALL take data_in at that edge.
REQ-020 On write_enable with write address >= DEPTH, no entry SHALL change and addr_err SHALL pulse the next cycle.
REQ-021 On write_enable with auto_inc=0, wr_ptr SHALL load addr+1, wrapping to 0 when addr+1 >= DEPTH.
REQ-022 On write_enable with auto_inc=1, wr_ptr SHALL increment, wrapping DEPTH-1 -> 0.
REQ-023 wr_ptr SHALL be unchanged in cycles without write_enable.
REQ-024 On read_enable, data_out SHALL show staging[addr] and rd_valid SHALL be 1 exactly one cycle later; latency 1.
REQ-025 Read with addr >= DEPTH SHALL give data_out=0, rd_valid=1, addr_err pulse.
REQ-026 Read and write to same address in one cycle SHALL return pre-write data.
REQ-027 data_out SHALL hold its last value while rd_valid=0.
REQ-028 On commit, every active[i] SHALL load staging[i] in that single edge; commit_done SHALL pulse the following cycle.
REQ-029 Commit coincident with write SHALL copy pre-write staging contents; the write SHALL land in staging only.
REQ-030 all_data_out SHALL change only on commit or reset, never on staging writes.
REQ-031 addr_err SHALL be 1 for one cycle if either a write or a read in that cycle is out of range.

Reset
REQ-032 Reset SHALL clear both banks, wr_ptr, data_out, rd_valid, addr_err, commit_done to 0 immediately, including mid-burst.
REQ-033 After reset deassertion the first write SHALL behave per REQ-018..022 with wr_ptr=0.

Verification
REQ-034 Reset, write addr=3 data=0xA5, no commit -> all_data_out all zero; read addr=3 -> next cycle data_out=0xA5, rd_valid=1.
REQ-035 Write addr=5 0x11, then auto_inc writes 0x22, 0x33 -> staging[5..7]=0x11,0x22,0x33; commit -> commit_done pulse, all_data_out words 5..7 match.
REQ-036 Write addr=124 0x7E, auto_inc write 0x01 (DEPTH=125) -> staging[0]=0x01, no addr_err.
REQ-037 Write addr=126 -> addr_err one-cycle pulse, no staging change; read addr=127 -> data_out=0, rd_valid=1, addr_err pulse.
REQ-038 staging[9]=0x40; same cycle commit and write addr=9 0x41 -> active[9]=0x40, staging[9]=0x41; second commit -> active[9]=0x41.
REQ-039 Assert reset mid auto_inc burst -> all outputs 0 at once; next auto_inc write lands at address 0.

Source files
------------

// File: rtl/config_memory_db_if.sv
// Bus bundle for the configuration memory: write/read/commit strobes in,
// registered readback, status pulses and the active bank out.
interface config_memory_db_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 125,
    parameter int ADDR_W = 7
);
    logic [DATA_W-1:0]       data_in;
    logic [ADDR_W-1:0]       addr;
    logic                    write_enable;
    logic                    auto_inc;
    logic                    read_enable;
    logic                    commit;
    logic [DATA_W-1:0]       data_out;
    logic                    rd_valid;
    logic                    addr_err;
    logic                    commit_done;
    logic [DEPTH*DATA_W-1:0] all_data_out;

    // Side that drives the strobes and consumes the results
    modport master (
        output data_in, addr, write_enable, auto_inc, read_enable, commit,
        input  data_out, rd_valid, addr_err, commit_done, all_data_out
    );

    // Side implemented by the memory itself
    modport slave (
        input  data_in, addr, write_enable, auto_inc, read_enable, commit,
        output data_out, rd_valid, addr_err, commit_done, all_data_out
    );
endinterface

// File: rtl/config_memory_db.sv
// Double-banked configuration store. Software fills the staging bank (by
// explicit address or via an auto-incrementing pointer), reads it back, and
// commits it atomically into the active bank that drives all_data_out.
module config_memory_db #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 125,
    parameter int ADDR_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    config_memory_db_if.slave bus
);
    localparam int               BANK_W  = DEPTH * DATA_W;
    // One extra bit so addr+1 never overflows before the range compare
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

    logic [BANK_W-1:0] staging_r;
    logic [BANK_W-1:0] active_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W:0]   addr_inc_s;
    logic [ADDR_W:0]   ptr_inc_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic              wr_err_s;
    logic              rd_err_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] data_out_r;
    logic              rd_valid_r;
    logic              addr_err_r;
    logic              commit_done_r;

    // Address selection, range checks and staging readback mux
    always_comb begin
        wr_addr_s = bus.addr;
        rd_data_s = '0;
        if (bus.auto_inc) begin
            wr_addr_s = wr_ptr_r;
        end else begin
            wr_addr_s = bus.addr;
        end
        wr_ok_s  = ({1'b0, wr_addr_s} < DEPTH_L);
        rd_ok_s  = ({1'b0, bus.addr} < DEPTH_L);
        wr_err_s = bus.write_enable & ~wr_ok_s;
        rd_err_s = bus.read_enable & ~rd_ok_s;
        if (rd_ok_s) begin
            rd_data_s = staging_r[int'(bus.addr) * DATA_W +: DATA_W];
        end else begin
            rd_data_s = '0;
        end
    end

    // Next write pointer: follows the last write, wrapping at DEPTH
    always_comb begin
        addr_inc_s   = {1'b0, bus.addr} + ONE_L;
        ptr_inc_s    = {1'b0, wr_ptr_r} + ONE_L;
        wr_ptr_nxt_s = wr_ptr_r;
        if (!bus.write_enable) begin
            wr_ptr_nxt_s = wr_ptr_r;
        end else if (bus.auto_inc) begin
            if (ptr_inc_s >= DEPTH_L) begin
                wr_ptr_nxt_s = '0;
            end else begin
                wr_ptr_nxt_s = ptr_inc_s[ADDR_W-1:0];
            end
        end else begin
            if (addr_inc_s >= DEPTH_L) begin
                wr_ptr_nxt_s = '0;
            end else begin
                wr_ptr_nxt_s = addr_inc_s[ADDR_W-1:0];
            end
        end
    end

    // Bank storage: commit snapshots pre-write staging, write lands in staging
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging_r <= '0;
            active_r  <= '0;
            wr_ptr_r  <= '0;
        end else begin
            if (bus.commit) begin
                active_r <= staging_r;
            end
            if (bus.write_enable && wr_ok_s) begin
                staging_r[int'(wr_addr_s) * DATA_W +: DATA_W] <= bus.data_in;
            end
            wr_ptr_r <= wr_ptr_nxt_s;
        end
    end

    // Registered readback and one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r    <= '0;
            rd_valid_r    <= 1'b0;
            addr_err_r    <= 1'b0;
            commit_done_r <= 1'b0;
        end else begin
            if (bus.read_enable) begin
                data_out_r <= rd_data_s;
            end
            rd_valid_r    <= bus.read_enable;
            addr_err_r    <= wr_err_s | rd_err_s;
            commit_done_r <= bus.commit;
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.rd_valid     = rd_valid_r;
    assign bus.addr_err     = addr_err_r;
    assign bus.commit_done  = commit_done_r;
    assign bus.all_data_out = active_r;
endmodule

// File: tb/tb_config_memory_db.sv
// Self-checking bench for config_memory_db: a reference model of both banks
// and the write pointer predicts every cycle; read results are queued when a
// read is issued and compared when rd_valid comes back.
module tb_config_memory_db;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 125;
    localparam int ADDR_W = 7;

    logic clk;
    logic reset;

    config_memory_db_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    config_memory_db #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total_cnt;
    int bad_cnt;

    logic [DATA_W-1:0]       m_stage [DEPTH];
    logic [DATA_W-1:0]       m_active[DEPTH];
    int                      m_ptr;
    logic [DATA_W-1:0]       m_last;
    logic [DATA_W-1:0]       rd_q[$];
    logic [DEPTH*DATA_W-1:0] zero_bank;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DEPTH*DATA_W-1:0] model_flat();
        logic [DEPTH*DATA_W-1:0] f;
        f = '0;
        for (int i = 0; i < DEPTH; i++) f[i*DATA_W +: DATA_W] = m_active[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_stage[i]  = 8'h00;
            m_active[i] = 8'h00;
        end
        m_ptr  = 0;
        m_last = 8'h00;
        rd_q.delete();
    endtask

    // One clock: predict from current inputs, clock, then compare outputs
    task automatic step();
        bit exp_err;
        bit exp_rv;
        bit exp_cd;
        int wa;
        int a;
        logic [DATA_W-1:0] got_d;
        a       = int'(bus.addr);
        wa      = bus.auto_inc ? m_ptr : a;
        exp_err = 1'b0;
        exp_rv  = bus.read_enable;
        exp_cd  = bus.commit;
        if (bus.read_enable) begin
            if (a < DEPTH) rd_q.push_back(m_stage[a]);
            else begin
                rd_q.push_back(8'h00);
                exp_err = 1'b1;
            end
        end
        if (bus.commit) begin
            for (int i = 0; i < DEPTH; i++) m_active[i] = m_stage[i];
        end
        if (bus.write_enable) begin
            if (wa < DEPTH) m_stage[wa] = bus.data_in;
            else exp_err = 1'b1;
            if (bus.auto_inc) m_ptr = (m_ptr + 1 >= DEPTH) ? 0 : m_ptr + 1;
            else m_ptr = (a + 1 >= DEPTH) ? 0 : a + 1;
        end
        @(posedge clk);
        #1;
        check_eq("rd_valid", 64'(bus.rd_valid), 64'(exp_rv));
        check_eq("addr_err", 64'(bus.addr_err), 64'(exp_err));
        check_eq("commit_done", 64'(bus.commit_done), 64'(exp_cd));
        check_eq("all_data_match", 64'(bus.all_data_out == model_flat()), 64'd1);
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                check_eq("rd_unexpected", 64'd1, 64'd0);
            end else begin
                got_d = rd_q.pop_front();
                check_eq("rd_data", 64'(bus.data_out), 64'(got_d));
                m_last = got_d;
            end
        end else begin
            check_eq("data_hold", 64'(bus.data_out), 64'(m_last));
        end
    endtask

    task automatic do_cycle(input bit we, input bit ai, input bit re, input bit cm,
                            input int a, input int d);
        bus.write_enable = we;
        bus.auto_inc     = ai;
        bus.read_enable  = re;
        bus.commit       = cm;
        bus.addr         = ADDR_W'(a);
        bus.data_in      = DATA_W'(d);
        step();
        bus.write_enable = 1'b0;
        bus.auto_inc     = 1'b0;
        bus.read_enable  = 1'b0;
        bus.commit       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data_out"}, 64'(bus.data_out), 64'd0);
        check_eq({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
        check_eq({tag, "_addr_err"}, 64'(bus.addr_err), 64'd0);
        check_eq({tag, "_commit_done"}, 64'(bus.commit_done), 64'd0);
        check_eq({tag, "_all_zero"}, 64'(bus.all_data_out == zero_bank), 64'd1);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        zero_bank = '0;
        reset = 1'b1;
        bus.write_enable = 1'b0;
        bus.auto_inc     = 1'b0;
        bus.read_enable  = 1'b0;
        bus.commit       = 1'b0;
        bus.addr         = '0;
        bus.data_in      = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Staging write is invisible on the active bank, readable next cycle
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3, 8'hA5);
        check_eq("no_commit_all_zero", 64'(bus.all_data_out == zero_bank), 64'd1);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 3, 0);

        // Explicit then auto-increment writes, commit
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5, 8'h11);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h22);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h33);
        for (int i = 5; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, i, 0);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        check_eq("active5", 64'(bus.all_data_out[5*DATA_W +: DATA_W]), 64'h11);
        check_eq("active6", 64'(bus.all_data_out[6*DATA_W +: DATA_W]), 64'h22);
        check_eq("active7", 64'(bus.all_data_out[7*DATA_W +: DATA_W]), 64'h33);

        // Pointer wraps from the last word to 0
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 124, 8'h7E);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h01);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 124, 0);

        // Out-of-range write and read
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 126, 8'hEE);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 127, 0);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Commit coincident with write copies pre-write contents
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 9, 8'h40);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 9, 8'h41);
        check_eq("active9_pre", 64'(bus.all_data_out[9*DATA_W +: DATA_W]), 64'h40);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 9, 0);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        check_eq("active9_post", 64'(bus.all_data_out[9*DATA_W +: DATA_W]), 64'h41);

        // Same-address read and write returns pre-write data
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 9, 8'h55);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 9, 0);

        // Randomised mix of all operations
        for (int n = 0; n < 300; n++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                     $urandom_range(0, 127), $urandom_range(0, 255));
        end

        // Reset in the middle of an auto-increment burst
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 20, 8'hA0);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'hA1);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 20, 8'hA2);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 50, 8'h5C);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 22, 0);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        check_eq("queue_empty", 64'(rd_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
